// File: rtl/popcount_accum7_if.sv
// rtl/popcount_accum7_if.sv - input word stream and frame result handshake for popcount_accum7
interface popcount_accum7_if #(
  parameter int ACC_W = 10,
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_count;
  logic [LEN_W-1:0] out_words;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_words, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_words, out_sat
  );
endinterface

// File: rtl/popcount_accum7.sv
// rtl/popcount_accum7.sv - per-frame saturating sum of 7-bit population counts
module counter7 (
  input  logic [6:0] data,
  output logic [2:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < 7; i++) count = count + {2'b00, data[i]};
  end
endmodule

module popcount_accum7 #(
  parameter int ACC_W = 10,
  parameter int LEN_W = 8
) (
  input logic          clk,
  input logic          rst,
  popcount_accum7_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] words;
  logic             sat;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_count_r;
  logic [LEN_W-1:0] out_words_r;
  logic             out_sat_r;

  logic [2:0]       cnt;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf;
  logic             wrd_ovf;
  logic [ACC_W-1:0] acc_n;
  logic [LEN_W-1:0] wrd_n;
  logic             in_ready;
  logic             accept;

  counter7 u_counter7 (
    .data  (bus.in_data),
    .count (cnt)
  );

  // One spare bit on the sum catches the carry out used for clamping.
  assign acc_sum  = {{(ACC_W-2){1'b0}}, cnt} + {1'b0, acc};
  assign acc_ovf  = acc_sum[ACC_W];
  assign acc_n    = acc_ovf ? '1 : acc_sum[ACC_W-1:0];
  assign wrd_ovf  = &words;
  assign wrd_n    = wrd_ovf ? words : words + LEN_W'(1);

  assign in_ready = (state == ACCUM) && !rst;
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_count = out_count_r;
  assign bus.out_words = out_words_r;
  assign bus.out_sat   = out_sat_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      acc         <= '0;
      words       <= '0;
      sat         <= 1'b0;
      out_valid_r <= 1'b0;
      out_count_r <= '0;
      out_words_r <= '0;
      out_sat_r   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (bus.in_last) begin
              out_count_r <= acc_n;
              out_words_r <= wrd_n;
              out_sat_r   <= sat | acc_ovf | wrd_ovf;
              out_valid_r <= 1'b1;
              acc         <= '0;
              words       <= '0;
              sat         <= 1'b0;
              state       <= HOLD;
            end else begin
              acc   <= acc_n;
              words <= wrd_n;
              sat   <= sat | acc_ovf | wrd_ovf;
            end
          end
        end
        HOLD: begin
          // Result data stays put after the handshake until the next frame ends.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
